dfm_regbank: RTL and testbench

Parametrised, multi-channel successor to the single-block configuration register file. It sits between the host command decoder and the frequency-measurement channels. It provides:
- per-channel staging registers written a full word at a time;
- an explicit, read-safe commit into shadow registers that drive the datapath;
- a byte-addressed, registered read port that also exposes read-only default constants.

A commit is never applied while a host read session is open, so a readback is always coherent.

---
 rtl/dfm_regbank.sv | 159 +++++++++++++++
 tb/tb_dfm_regbank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfm_regbank.sv
// Multi-channel config register bank: full-word staging, read-safe commit to shadow, 1-cycle registered byte read port.
// Latency: writes/commits visible on the next edge, reads valid one cycle after request. Optional macro: REGBANK_DEFER_COMMIT_EN.
// Backpressure: none; a commit during a read session is deferred (macro defined) or dropped with an error pulse (default).
module dfm_regbank #(
    parameter int          CH_NUM                  = 2,
    parameter int          CH_BYTES                = 8,
    parameter logic [31:0] DEFAULT_GATE_TIME_SHIFT = 32'h0000_0000,
    parameter logic [31:0] DEFAULT_GATE_TIME_TOTAL = 32'h0000_0000,
    localparam int         ADDR_W                  = $clog2(8 + CH_NUM*CH_BYTES),
    localparam int         CH_W                    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           reg_wr_en_i,
    input  logic [CH_W-1:0]                reg_wr_ch_i,
    input  logic [CH_BYTES*8-1:0]          reg_wr_data_i,
    input  logic                           reg_commit_i,
    input  logic                           reg_rd_en_i,
    input  logic [ADDR_W-1:0]              reg_rd_addr_i,
    output logic [7:0]                     reg_rd_data_o,
    output logic                           reg_rd_valid_o,
    output logic [CH_NUM-1:0]              reg_dirty_o,
    output logic                           reg_commit_pend_o,
    output logic                           reg_commit_err_o,
    output logic [CH_NUM*CH_BYTES*8-1:0]   reg_shadow_o
);

    localparam int WORD_W    = CH_BYTES*8;
    localparam int TOT_BYTES = CH_NUM*CH_BYTES;

    logic [WORD_W-1:0]        r_stage [CH_NUM];
    logic [TOT_BYTES*8-1:0]   r_shadow;
    logic [CH_NUM-1:0]        r_dirty;
    logic [7:0]               r_rd_data;
    logic                     r_rd_valid;
    logic [CH_NUM-1:0]        w_wr_hit;
    logic                     w_commit;
    logic [7:0]               w_rd_byte;

    // Out-of-range channel numbers match no channel, so such writes vanish.
    always_comb begin
        w_wr_hit = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (reg_wr_en_i && (reg_wr_ch_i == CH_W'(c))) begin
                w_wr_hit[c] = 1'b1;
            end
        end
    end

`ifdef REGBANK_DEFER_COMMIT_EN
    typedef enum logic {ST_IDLE, ST_PEND} state_t;
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commits arriving while PEND merge into the one already waiting.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reg_commit_i) begin
                    if (reg_rd_en_i) begin
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (!reg_rd_en_i) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign reg_commit_pend_o = (r_state == ST_PEND);
    assign reg_commit_err_o  = 1'b0;
`else
    logic r_commit_err;

    assign w_commit = reg_commit_i && !reg_rd_en_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_commit_err <= 1'b0;
        end else begin
            r_commit_err <= reg_commit_i && reg_rd_en_i;
        end
    end

    assign reg_commit_pend_o = 1'b0;
    assign reg_commit_err_o  = r_commit_err;
`endif

    // Shadow copies the pre-edge staging, so a same-cycle write stays dirty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                r_stage[c] <= '0;
            end
            r_shadow <= '0;
            r_dirty  <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_wr_hit[c]) begin
                    r_stage[c] <= reg_wr_data_i;
                end
            end
            if (w_commit) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    r_shadow[c*WORD_W +: WORD_W] <= r_stage[c];
                end
                r_dirty <= w_wr_hit;
            end else begin
                r_dirty <= r_dirty | w_wr_hit;
            end
        end
    end

    always_comb begin
        w_rd_byte = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (reg_rd_addr_i == ADDR_W'(i)) w_rd_byte = DEFAULT_GATE_TIME_SHIFT[i*8 +: 8];
            if (reg_rd_addr_i == ADDR_W'(i + 4)) w_rd_byte = DEFAULT_GATE_TIME_TOTAL[i*8 +: 8];
        end
        for (int i = 0; i < TOT_BYTES; i++) begin
            if (reg_rd_addr_i == ADDR_W'(i + 8)) w_rd_byte = r_shadow[i*8 +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= reg_rd_en_i;
            if (reg_rd_en_i) begin
                r_rd_data <= w_rd_byte;
            end
        end
    end

    assign reg_rd_data_o  = r_rd_data;
    assign reg_rd_valid_o = r_rd_valid;
    assign reg_dirty_o    = r_dirty;
    assign reg_shadow_o   = r_shadow;

endmodule

// File: tb/tb_dfm_regbank.sv
// Self-checking bench for dfm_regbank (CH_NUM=2, CH_BYTES=8); read data checked through an expected-byte queue.
module tb_dfm_regbank;

    localparam logic [31:0] SHIFT = 32'h1122_3344;
    localparam logic [31:0] TOTAL = 32'h5566_7788;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [0:0]    wr_ch;
    logic [63:0]   wr_data;
    logic          commit;
    logic          rd_en;
    logic [4:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [1:0]    dirty;
    logic          pend;
    logic          err;
    logic [127:0]  shadow;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0]   sb_q[$];
    logic [127:0] m_shadow = '0;

    dfm_regbank #(
        .CH_NUM                  (2),
        .CH_BYTES                (8),
        .DEFAULT_GATE_TIME_SHIFT (SHIFT),
        .DEFAULT_GATE_TIME_TOTAL (TOTAL)
    ) u_dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .reg_wr_en_i       (wr_en),
        .reg_wr_ch_i       (wr_ch),
        .reg_wr_data_i     (wr_data),
        .reg_commit_i      (commit),
        .reg_rd_en_i       (rd_en),
        .reg_rd_addr_i     (rd_addr),
        .reg_rd_data_o     (rd_data),
        .reg_rd_valid_o    (rd_valid),
        .reg_dirty_o       (dirty),
        .reg_commit_pend_o (pend),
        .reg_commit_err_o  (err),
        .reg_shadow_o      (shadow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        logic [31:0] s;
        logic [31:0] t;
        s = SHIFT;
        t = TOTAL;
        if (a < 4)  return s[a*8 +: 8];
        if (a < 8)  return t[(a-4)*8 +: 8];
        if (a < 24) return m_shadow[(a-8)*8 +: 8];
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_unexpected", 1'b1, 1'b0);
            end else begin
                chk("rd_data", rd_data, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input int a);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        sb_q.push_back(exp_byte(a));
    endtask

    task automatic do_write(input logic ch, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        commit = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_dirty", dirty, 2'b00);
        chk("rst_pend", pend, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_shadow", shadow, 128'h0);
        rst_n = 1'b1;
        tick();

        // Constants and first shadow byte, back to back, then out-of-range.
        for (int a = 0; a <= 8; a++) begin
            issue_rd(a);
            tick();
        end
        issue_rd(24); tick();
        issue_rd(31); tick();
        issue_rd(3);  tick();
        rd_en = 1'b0;
        tick();
        chk("rd_idle_valid", rd_valid, 1'b0);
        chk("rd_idle_hold", rd_data, 8'h11);

        do_write(1'b1, 64'h0807_0605_0403_0201);
        chk("wr_dirty", dirty, 2'b10);
        chk("wr_shadow_unchanged", shadow, m_shadow);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        m_shadow = {64'h0807_0605_0403_0201, 64'h0};
        chk("commit_dirty", dirty, 2'b00);
        chk("commit_shadow", shadow, m_shadow);
        issue_rd(16); tick();
        issue_rd(23); tick();
        rd_en = 1'b0;
        tick();

        // Same-cycle write and commit to ch0.
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 64'hAA; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        chk("wc_shadow_old", shadow, m_shadow);
        chk("wc_dirty_kept", dirty, 2'b01);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        m_shadow[63:0] = 64'hAA;
        chk("wc_shadow_new", shadow, m_shadow);
        chk("wc_dirty_clr", dirty, 2'b00);

        do_write(1'b1, 64'hDEAD_BEEF_0000_1111);
`ifdef REGBANK_DEFER_COMMIT_EN
        for (int i = 1; i <= 5; i++) begin
            issue_rd(8);
            commit = (i == 1 || i == 3);
            tick();
            commit = 1'b0;
            chk("pend_hold", pend, 1'b1);
            chk("pend_shadow_hold", shadow, m_shadow);
            chk("pend_err", err, 1'b0);
        end
        rd_en = 1'b0;
        tick();
        m_shadow[127:64] = 64'hDEAD_BEEF_0000_1111;
        chk("pend_fall", pend, 1'b0);
        chk("pend_applied", shadow, m_shadow);
        chk("pend_dirty", dirty, 2'b00);
`else
        issue_rd(8);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        rd_en  = 1'b0;
        chk("drop_err", err, 1'b1);
        chk("drop_shadow", shadow, m_shadow);
        chk("drop_dirty", dirty, 2'b10);
        chk("drop_pend", pend, 1'b0);
        tick();
        chk("drop_err_pulse", err, 1'b0);
        chk("drop_shadow_after", shadow, m_shadow);
`endif

        // Reset with a read session open and a commit requested.
        do_write(1'b0, 64'h55);
        issue_rd(9);
        commit = 1'b1;
        tick();
`ifdef REGBANK_DEFER_COMMIT_EN
        chk("pre_rst_pend", pend, 1'b1);
`endif
        @(negedge clk);
        #1;
        rst_n = 1'b0; rd_en = 1'b0; commit = 1'b0;
        #1;
        m_shadow = '0;
        chk("arst_pend", pend, 1'b0);
        chk("arst_shadow", shadow, 128'h0);
        chk("arst_dirty", dirty, 2'b00);
        chk("arst_valid", rd_valid, 1'b0);
        chk("arst_rd_data", rd_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_shadow", shadow, 128'h0);
        do_write(1'b1, 64'h1234_5678_9ABC_DEF0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        m_shadow[127:64] = 64'h1234_5678_9ABC_DEF0;
        chk("post_rst_commit", shadow, m_shadow);
        chk("post_rst_dirty", dirty, 2'b00);
        issue_rd(20); tick();
        rd_en = 1'b0;
        repeat (2) tick();

        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
